bias_fetch_ctrl: RTL and testbench
==================================

# bias_fetch_ctrl

Sequencer that loads one output-channel group of bias values from `bias_rom` into a bank of per-column bias registers feeding the systolic array's output/requantization stage. On a `start` handshake it issues `NUM_COLS` consecutive ROM reads for `(layer_idx, base_ch + k)`, aligns the one-cycle ROM latency, and zero-fills channels beyond the layer's channel count. It then presents the packed bias vector with a `done` pulse and a level `bias_valid`. It sits between the layer/tile scheduler and `bias_rom`, and is the only master of the ROM's read port.

## Interface
- `WIDTH`, 32, bias bit width (matches ROM)
- `NUM_LAYERS`, 6, number of CNN layers
- `MAX_NUM_CH`, 64, maximum output channels per layer
- `CH_BITS`, $clog2(MAX_NUM_CH), channel index width
- `NUM_COLS`, 4, bias registers per group (systolic array columns)
- `CONV_OUT_C`, '{8,16,32,64,64,10}, output channels per layer (int array [NUM_LAYERS])

Ports:
- `clk` input 1: single clock, all state on posedge
- `reset` input 1: synchronous, active-high
- `start` input 1: request a group load; sampled only in IDLE
- `layer_idx` input $clog2(NUM_LAYERS): layer of the request, latched on accept
- `base_ch` input CH_BITS: first output channel of the group, latched on accept
- `busy` output 1: high in every state except IDLE
- `done` output 1: one-cycle pulse when the group is loaded
- `bias_valid` output 1: bias_vec holds a complete group
- `layer_err` output 1: latched layer_idx >= NUM_LAYERS for the current/last group
- `bias_vec` output NUM_COLS*WIDTH: packed biases; column k at bits [k*WIDTH +: WIDTH]
- `rom_read_enable` output 1: to bias_rom.read_enable
- `rom_layer_idx` output $clog2(NUM_LAYERS): to bias_rom.layer_idx
- `rom_channel_idx` output CH_BITS: to bias_rom.channel_idx
- `rom_bias` input WIDTH: from bias_rom.bias_out; valid one cycle after a read-enabled cycle

## Operation
- Clocking: one clock; synchronous active-high reset (fixed).
- FSM states: IDLE, FETCH, DRAIN, DONE.
  - IDLE & start: latch layer_idx/base_ch, clear bias_valid, set layer_err if layer_idx >= NUM_LAYERS, k<=0, go to FETCH.
  - FETCH: one slot per cycle, k = 0..NUM_COLS-1; go to DRAIN after the slot with k = NUM_COLS-1.
  - DRAIN: one cycle, captures the last column, then go to DONE.
  - DONE: done=1, bias_valid<=1, then go to IDLE.
- Slot k channel: `ch = base_ch + k`, computed in CH_BITS+1 bits (no wrap).
  - In-range: layer valid and ch < CONV_OUT_C[layer]. Drive rom_read_enable=1, rom_layer_idx=latched layer, rom_channel_idx=ch[CH_BITS-1:0].
  - Out-of-range: rom_read_enable=0. The column is forced to zero by the controller, independent of rom_bias.
- Capture pipeline: registered slot-valid, slot-index and in-range flag. On the cycle after slot k, write column k <= in-range ? rom_bias : 0.
- Outside FETCH: rom_read_enable=0, rom_layer_idx=0, rom_channel_idx=0.
- start outside IDLE is ignored; no queuing.
- bias_vec:
  - Keeps its previous group until overwritten column by column in the next load.
  - bias_valid is low from the accepting edge until DONE.
- layer_err holds until the next accepted start.

## Timing
- Cycle 0: start high in IDLE.
- Cycles 1..NUM_COLS: FETCH, slot k in cycle k+1.
- Column k is written at the end of cycle k+2.
- Cycle NUM_COLS+1: DRAIN.
- Cycle NUM_COLS+2: DONE, with done=1 and bias_vec complete and stable.
- bias_valid is high from cycle NUM_COLS+3.
- Earliest next accept: start high in cycle NUM_COLS+3 (IDLE). Load-to-load period is NUM_COLS+3 cycles.
- Reset, including mid-operation:
  - State returns to IDLE.
  - busy, done, bias_valid, layer_err = 0; bias_vec = 0.
  - ROM outputs = 0; pipeline valids cleared.
  - Reset has priority over start.

## Test plan
- Layer 1, base_ch 0 (ROM rows 8..11 = 0x11,0x22,0x33,0x44): rom_channel_idx 0,1,2,3 in cycles 1–4 with enable; done in cycle 6; bias_vec columns = 0x11,0x22,0x33,0x44; bias_valid from cycle 7.
- Layer 5, base_ch 8 (10 channels): enables only for ch 8,9; columns 2,3 = 0 even when rom_bias is forced nonzero; layer_err=0.
- layer_idx 7 (invalid): no rom_read_enable in any cycle; bias_vec all zero; done in cycle 6; layer_err=1 until the next accepted start.
- start held high continuously: accepts at cycles 0 and 7 only; busy low exactly in cycle 7; second group overwrites the first.
- Reset asserted in cycle 3 of a fetch: the next cycle shows IDLE, all outputs 0, no done. A fresh start afterwards completes normally with correct values.
- Layer 3, base_ch 62 (64 channels): ch 62,63 read; ch 64,65 zero-filled; rom_channel_idx never wraps to 0/1 with enable high.

Source files
------------

// File: rtl/bias_fetch_ctrl.sv
// bias_fetch_ctrl: loads one channel group of biases from bias_rom into per-column registers
module bias_fetch_ctrl #(
  parameter int WIDTH = 32,
  parameter int NUM_LAYERS = 6,
  parameter int MAX_NUM_CH = 64,
  parameter int CH_BITS = $clog2(MAX_NUM_CH),
  parameter int NUM_COLS = 4,
  parameter int CONV_OUT_C [NUM_LAYERS] = '{8, 16, 32, 64, 64, 10}
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [$clog2(NUM_LAYERS)-1:0] layer_idx,
  input  logic [CH_BITS-1:0]            base_ch,
  output logic                          busy,
  output logic                          done,
  output logic                          bias_valid,
  output logic                          layer_err,
  output logic [NUM_COLS*WIDTH-1:0]     bias_vec,
  output logic                          rom_read_enable,
  output logic [$clog2(NUM_LAYERS)-1:0] rom_layer_idx,
  output logic [CH_BITS-1:0]            rom_channel_idx,
  input  logic [WIDTH-1:0]              rom_bias
);
  localparam int LW = $clog2(NUM_LAYERS);
  localparam int KW = NUM_COLS > 1 ? $clog2(NUM_COLS) : 1;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [LW-1:0] lay_q;
  logic [CH_BITS-1:0] base_q;
  logic [KW-1:0] k, cap_k;
  logic cap_v, cap_in, rd;
  logic [CH_BITS:0] ch, lim;
  always_comb begin
    lim = '0;
    for (int i = 0; i < NUM_LAYERS; i++)
      if (lay_q == LW'(i)) lim = (CH_BITS+1)'(CONV_OUT_C[i]);
    ch = {1'b0, base_q} + (CH_BITS+1)'(k);
    rd = state == FETCH && !layer_err && ch < lim;
    state_n = state == IDLE  ? (start ? FETCH : IDLE) :
              state == FETCH ? (k == KW'(NUM_COLS-1) ? DRAIN : FETCH) :
              state == DRAIN ? DONE : IDLE;
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign rom_read_enable = rd;
  assign rom_layer_idx = rd ? lay_q : '0;
  assign rom_channel_idx = rd ? ch[CH_BITS-1:0] : '0;
  // column k captures the ROM word one cycle after its slot; out-of-range slots zero-fill
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      lay_q <= '0;
      base_q <= '0;
      k <= '0;
      cap_v <= 1'b0;
      cap_k <= '0;
      cap_in <= 1'b0;
      bias_vec <= '0;
      bias_valid <= 1'b0;
      layer_err <= 1'b0;
    end else begin
      state <= state_n;
      cap_v <= state == FETCH;
      cap_k <= k;
      cap_in <= rd;
      k <= state == FETCH ? k + KW'(1) : '0;
      if (state == IDLE && start) begin
        lay_q <= layer_idx;
        base_q <= base_ch;
        bias_valid <= 1'b0;
        layer_err <= int'(layer_idx) >= NUM_LAYERS;
      end
      if (state == DONE) bias_valid <= 1'b1;
      for (int i = 0; i < NUM_COLS; i++)
        if (cap_v && cap_k == KW'(i)) bias_vec[i*WIDTH +: WIDTH] <= cap_in ? rom_bias : '0;
    end
  end
endmodule

// File: tb/tb_bias_fetch_ctrl.sv
// tb_bias_fetch_ctrl: table-driven group loads plus held-start and mid-fetch reset sequences
module tb_bias_fetch_ctrl;
  localparam int W = 32, NC = 4, CB = 6, LW = 3;
  logic clk = 0, reset = 1, start = 0;
  logic [LW-1:0] layer_idx = '0;
  logic [CB-1:0] base_ch = '0;
  logic busy, done, bias_valid, layer_err, rom_read_enable;
  logic [NC*W-1:0] bias_vec;
  logic [LW-1:0] rom_layer_idx;
  logic [CB-1:0] rom_channel_idx;
  logic [W-1:0] rom_bias = '0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  bias_fetch_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .layer_idx(layer_idx), .base_ch(base_ch),
    .busy(busy), .done(done), .bias_valid(bias_valid), .layer_err(layer_err),
    .bias_vec(bias_vec), .rom_read_enable(rom_read_enable), .rom_layer_idx(rom_layer_idx),
    .rom_channel_idx(rom_channel_idx), .rom_bias(rom_bias)
  );

  function automatic logic [W-1:0] rom_val(input logic [LW-1:0] l, input logic [CB-1:0] c);
    return (l == 1) ? 32'h11 * (32'(c) + 1) : {8'(8'hB0 + 8'(l)), 16'h0, 2'b0, c};
  endfunction

  // one-cycle ROM; garbage when not enabled so zero-fill must come from the controller
  always @(posedge clk)
    rom_bias <= rom_read_enable ? rom_val(rom_layer_idx, rom_channel_idx) : 32'hDEADBEEF;

  task automatic chk(input string n, input logic [NC*W-1:0] a, input logic [NC*W-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  typedef struct {
    logic [LW-1:0]   l;
    logic [CB-1:0]   b;
    logic [NC*W-1:0] vec;
    logic [NC-1:0]   en;
    logic            err;
  } vec_t;
  vec_t tbl [5];

  task automatic run(input vec_t v);
    logic [NC-1:0] en_seen;
    @(negedge clk);
    start = 1; layer_idx = v.l; base_ch = v.b;
    chk("idle_busy", busy, 0);
    @(negedge clk);
    start = 0;
    en_seen = '0;
    for (int c = 1; c <= 7; c++) begin
      if (c <= NC) begin
        en_seen[c-1] = rom_read_enable;
        if (rom_read_enable) begin
          chk("rom_ch", rom_channel_idx, v.b + CB'(c-1));
          chk("rom_layer", rom_layer_idx, v.l);
        end
      end else chk("rom_en_off", rom_read_enable, 0);
      chk("busy", busy, c != 7);
      chk("done", done, c == 6);
      chk("valid", bias_valid, c == 7);
      if (c == 1) chk("err", layer_err, v.err);
      if (c == 6) chk("vec", bias_vec, v.vec);
      if (c == 7) begin
        chk("en_mask", en_seen, v.en);
        chk("err_hold", layer_err, v.err);
        chk("vec_hold", bias_vec, v.vec);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    tbl[0] = '{3'd1, 6'd0,  {32'h44, 32'h33, 32'h22, 32'h11}, 4'b1111, 1'b0};
    tbl[1] = '{3'd5, 6'd8,  {32'h0, 32'h0, 32'hB5000009, 32'hB5000008}, 4'b0011, 1'b0};
    tbl[2] = '{3'd7, 6'd0,  '0, 4'b0000, 1'b1};
    tbl[3] = '{3'd3, 6'd62, {32'h0, 32'h0, 32'hB300003F, 32'hB300003E}, 4'b0011, 1'b0};
    tbl[4] = '{3'd0, 6'd6,  {32'h0, 32'h0, 32'hB0000007, 32'hB0000006}, 4'b0011, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", bias_valid, 0);
    chk("rst_err", layer_err, 0);
    chk("rst_vec", bias_vec, 0);
    chk("rst_rom", {rom_read_enable, rom_layer_idx, rom_channel_idx}, 0);
    reset = 0;
    for (int i = 0; i < 5; i++) run(tbl[i]);
    // start held high: accepts at cycles 0 and 7, second group overwrites the first
    @(negedge clk);
    start = 1; layer_idx = 1; base_ch = 0;
    for (int c = 0; c <= 14; c++) begin
      chk("hold_busy", busy, !(c == 0 || c == 7 || c == 14));
      if (c == 1) layer_idx = 0;
      if (c == 6) chk("hold_vec1", bias_vec, tbl[0].vec);
      if (c == 13) begin
        chk("hold_done2", done, 1);
        start = 0;
      end
      if (c == 14) begin
        chk("hold_vec2", bias_vec, {32'hB0000003, 32'hB0000002, 32'hB0000001, 32'hB0000000});
        chk("hold_valid2", bias_valid, 1);
      end
      @(negedge clk);
    end
    // reset in cycle 3 of a fetch
    start = 1; layer_idx = 1; base_ch = 0;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_valid", bias_valid, 0);
    chk("mrst_err", layer_err, 0);
    chk("mrst_vec", bias_vec, 0);
    chk("mrst_rom", {rom_read_enable, rom_layer_idx, rom_channel_idx}, 0);
    reset = 0;
    run(tbl[0]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
